acc_diff: RTL and testbench

//  Inverse of the accumulator: consumes the running-sum stream an acc block drives on data_out.

---
 rtl/acc_pkg.sv | 20 ++
 rtl/acc_fifo.sv | 75 +++++++
 rtl/acc_diff.sv | 113 +++++++++++
 tb/tb_acc_diff.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// Shared types and constants for the acc_diff running-sum decoder.
// The entry struct only exists when ACC_DIFF_STAMP_EN is defined.
package acc_pkg;

  localparam int ACC_WIDTH = 32;
  localparam int STAMP_W   = 32;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } acc_diff_state_t;

`ifdef ACC_DIFF_STAMP_EN
  typedef struct packed {
    logic [STAMP_W-1:0]   stamp;
    logic [ACC_WIDTH-1:0] delta;
  } acc_entry_t;
`endif

endpackage

// File: rtl/acc_fifo.sv
// First-word fall-through FIFO with occupancy count and synchronous clear.
// When empty, dout keeps showing the most recently popped entry.
module acc_fifo #(
  parameter int DEPTH = 4,
  parameter int EW    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [EW-1:0]          din,
  output logic [EW-1:0]          dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic [EW-1:0] hold_q, hold_d;
  logic          push_ok, pop_ok;

  assign empty   = (lvl_q == '0);
  assign full    = (lvl_q == (AW+1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign level   = lvl_q;
  assign dout    = empty ? hold_q : mem_q[rd_q];

  always_comb begin
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    lvl_d  = lvl_q;
    hold_d = hold_q;
    if (clr) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_q] = din;
        wr_d        = wr_q + 1'b1;
      end
      if (pop_ok) begin
        hold_d = mem_q[rd_q];
        rd_d   = rd_q + 1'b1;
      end
      lvl_d = lvl_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      lvl_q  <= '0;
      hold_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      lvl_q  <= lvl_d;
      hold_q <= hold_d;
    end
  end

endmodule

// File: rtl/acc_diff.sv
// Recovers per-sample increments from an accumulator's running-sum stream.
// Define ACC_DIFF_STAMP_EN to attach a sample-time stamp to every delta (stamp_out).
module acc_diff
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   sum_vld,
  input  logic [WIDTH-1:0]       sum_in,
  output logic                   delta_vld,
  input  logic                   delta_rdy,
  output logic [WIDTH-1:0]       delta_out,
  output logic                   rst_seen,
  output logic                   ovf,
`ifdef ACC_DIFF_STAMP_EN
  output logic [STAMP_W-1:0]     stamp_out,
`endif
  output logic [$clog2(DEPTH):0] level
);

`ifdef ACC_DIFF_STAMP_EN
  localparam int EW = WIDTH + STAMP_W;
`else
  localparam int EW = WIDTH;
`endif

  acc_diff_state_t state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             ovf_q, ovf_d;
  logic             rst_seen_q, rst_seen_d;

  logic             take, is_rep, is_rst, push_req, pop, drop, push;
  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] delta;
  logic [EW-1:0]    entry_in, entry_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      prev_q     <= '0;
      ovf_q      <= 1'b0;
      rst_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      ovf_q      <= ovf_d;
      rst_seen_q <= rst_seen_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr)       state_d = RUN;
    else if (drop) state_d = HALT;
  end

  // Sample classification; a dropped push still advances prev.
  always_comb begin
    take     = (state_q == RUN) & sum_vld;
    is_rep   = (sum_in == prev_q);
    is_rst   = (sum_in == '0) & (prev_q != '0);
    delta    = sum_in - prev_q;
    push_req = take & ~is_rep & ~is_rst;
    pop      = delta_vld & delta_rdy;
    drop     = push_req & fifo_full & ~pop & ~clr;
    push     = push_req & ~drop & ~clr;
    prev_d     = clr ? '0 : (take ? sum_in : prev_q);
    ovf_d      = ~clr & (ovf_q | drop);
    rst_seen_d = ~clr & take & is_rst;
  end

`ifdef ACC_DIFF_STAMP_EN
  logic [STAMP_W-1:0] cnt_q, cnt_d;

  assign cnt_d = clr ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign entry_in  = {cnt_q, delta};
  assign stamp_out = entry_out[WIDTH +: STAMP_W];
`else
  assign entry_in = delta;
`endif

  acc_fifo #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .clr   (clr),
    .push  (push),
    .pop   (delta_rdy),
    .din   (entry_in),
    .dout  (entry_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign delta_vld = ~fifo_empty;
  assign delta_out = entry_out[WIDTH-1:0];
  assign rst_seen  = rst_seen_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_acc_diff.sv
// Scoreboard bench for acc_diff: a queue-based model predicts deltas, a negedge monitor checks pops.
module tb_acc_diff;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         clr;
  logic         sum_vld;
  logic [W-1:0] sum_in;
  logic         delta_vld;
  logic         delta_rdy;
  logic [W-1:0] delta_out;
  logic         rst_seen;
  logic         ovf;
  logic [2:0]   level;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [W-1:0] m_prev;
  bit           m_halt, m_ovf, m_rst;
  int           m_level;

  acc_diff #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .sum_vld   (sum_vld),
    .sum_in    (sum_in),
    .delta_vld (delta_vld),
    .delta_rdy (delta_rdy),
    .delta_out (delta_out),
    .rst_seen  (rst_seen),
    .ovf       (ovf),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the negedge removes the head at the next posedge.
  always @(negedge clk) begin
    if (reset === 1'b1 && delta_vld === 1'b1 && delta_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_delta: got %0h, expected no output", delta_out);
      end else begin
        mon_e = exp_q.pop_front();
        chk("delta_out", delta_out, mon_e);
      end
    end
  end

  function automatic void model_reset();
    exp_q.delete();
    m_prev  = '0;
    m_halt  = 0;
    m_ovf   = 0;
    m_rst   = 0;
    m_level = 0;
  endfunction

  // Drive one cycle of stimulus (called at posedge+1), advance the model, check after the edge.
  task automatic step(input bit sv, input logic [W-1:0] s, input bit rdy, input bit c);
    bit           pop_m, push_m;
    logic [W-1:0] d;
    d         = '0;
    sum_vld   = sv;
    sum_in    = s;
    delta_rdy = c ? 1'b0 : rdy;
    clr       = c;
    if (c) begin
      model_reset();
    end else begin
      pop_m  = (m_level > 0) && rdy;
      push_m = 0;
      m_rst  = 0;
      if (!m_halt && sv) begin
        if (s == m_prev) begin
          push_m = 0;
        end else if (s == '0) begin
          m_rst = 1;
        end else begin
          push_m = 1;
          d      = s - m_prev;
        end
        m_prev = s;
      end
      if (push_m) begin
        if (m_level == D && !pop_m) begin
          m_ovf  = 1;
          m_halt = 1;
        end else begin
          exp_q.push_back(d);
          m_level++;
        end
      end
      if (pop_m) m_level--;
    end
    @(posedge clk);
    #1;
    chk("level", level, m_level);
    chk("ovf", ovf, m_ovf);
    chk("rst_seen", rst_seen, m_rst);
    chk("delta_vld", delta_vld, m_level > 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 1, 0);
  endtask

  logic [W-1:0] t1_sums [6];
  logic [W-1:0] rs;

  initial begin
    reset     = 1'b0;
    clr       = 1'b0;
    sum_vld   = 1'b0;
    sum_in    = '0;
    delta_rdy = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_delta_vld", delta_vld, 0);
    chk("rst_delta_out", delta_out, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_rst_seen", rst_seen, 0);
    reset = 1'b1;

    // Plain accumulator sequence with a repeated sum.
    t1_sums = '{32'h10, 32'h15, 32'h3C, 32'h3C, 32'h3C, 32'h6C};
    step(0, '0, 0, 1);
    for (int i = 0; i < 6; i++) step(1, t1_sums[i], 1, 0);
    drain(3);

    // Backpressure into overflow, then drain while halted.
    step(0, '0, 0, 1);
    for (int i = 1; i <= 6; i++) step(1, W'(i), 0, 0);
    chk("ovf_level_full", level, 4);
    chk("ovf_sticky", ovf, 1);
    for (int i = 0; i < 4; i++) step(1, W'(100 + i), 1, 0);
    drain(2);

    // Full FIFO with simultaneous push and pop.
    step(0, '0, 0, 1);
    for (int i = 1; i <= 4; i++) step(1, W'(i), 0, 0);
    step(1, 32'd11, 1, 0);
    chk("full_pushpop_level", level, 4);
    chk("full_pushpop_ovf", ovf, 0);
    drain(6);

    // Accumulator reset in the stream.
    step(0, '0, 0, 1);
    step(1, 32'h20, 1, 0);
    step(1, 32'h00, 1, 0);
    step(1, 32'h08, 1, 0);
    drain(3);

    // Modular wrap.
    step(0, '0, 0, 1);
    step(1, 32'hFFFF_FFF0, 1, 0);
    step(1, 32'h0000_0010, 1, 0);
    drain(3);

    // Asynchronous reset between edges with entries buffered.
    step(0, '0, 0, 1);
    for (int i = 1; i <= 3; i++) step(1, W'(i), 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("async_delta_vld", delta_vld, 0);
    chk("async_level", level, 0);
    chk("async_ovf", ovf, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    step(1, 32'h05, 1, 0);
    drain(2);

    // Randomized stream.
    for (int n = 0; n < 600; n++) begin
      int  r;
      bit  c, sv, rdy;
      c  = ($urandom_range(0, 39) == 0);
      sv = ($urandom_range(0, 3) != 0);
      r  = $urandom_range(0, 9);
      if (r == 0)      rs = '0;
      else if (r == 1) rs = m_prev;
      else if (r == 2) rs = $urandom;
      else             rs = m_prev + W'($urandom_range(1, 50));
      rdy = ($urandom_range(0, 2) != 0);
      step(sv, rs, rdy, c);
    end
    drain(8);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
